// File: rtl/siso_shift_ctrl_if.sv
// Handshake bundle between the SISO shift controller and its parallel
// producer/consumer.
//   in_valid/in_data/in_ready    : word to serialize (producer -> controller)
//   out_valid/out_data/out_ready : reassembled word (controller -> consumer)
// The controller uses the slave modport. The producer/consumer side uses the
// master modport.
interface siso_shift_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/siso_shift_ctrl.sv
// Loopback/serializer sequencer for an external DEPTH-stage SISO right-shift
// register. It accepts a word and drives it LSB-first on sr_si. It then flushes
// the chain with zeros, rebuilds the word from the bits that emerge on sr_so,
// and offers the result on the output handshake.
// Ports:
//   clk, rst : clock; asynchronous active-high reset
//   bus      : in/out valid-ready handshake (slave modport)
//   sr_en    : shift enable to the SISO chain
//   sr_si    : serial bit into the chain
//   sr_so    : serial bit out of the chain (registered last stage)
//   busy     : high while shifting or flushing
//   bit_cnt  : shift cycles completed in the current transfer
module siso_shift_ctrl #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(WIDTH + DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    siso_shift_ctrl_if.slave    bus,
    output logic                sr_en,
    output logic                sr_si,
    input  logic                sr_so,
    output logic                busy,
    output logic [CW-1:0]       bit_cnt
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_FLUSH = CW'(WIDTH + DEPTH - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] tx_r;
    logic [WIDTH-1:0] rx_r;
    logic [WIDTH-1:0] rx_next_s;
    logic [WIDTH-1:0] out_data_r;
    logic [CW-1:0]    bit_cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             shifting_r;
    logic             in_ready_nxt_s;
    logic             out_valid_nxt_s;
    logic             shifting_nxt_s;
    logic             accept_s;

    assign accept_s = (state_r == IDLE) && bus.in_valid && in_ready_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_cnt_r == LAST_SHIFT) begin
                    next_state_s = FLUSH;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            FLUSH: begin
                if (bit_cnt_r == LAST_FLUSH) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = FLUSH;
                end
            end
            DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode. The decode uses the next state, so the registered flags
    // line up with the state they describe.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        shifting_nxt_s  = 1'b0;
        case (next_state_s)
            IDLE:    in_ready_nxt_s  = 1'b1;
            SHIFT:   shifting_nxt_s  = 1'b1;
            FLUSH:   shifting_nxt_s  = 1'b1;
            DONE:    out_valid_nxt_s = 1'b1;
            default: in_ready_nxt_s  = 1'b0;
        endcase
    end

    // Output flag registers. in_ready stays low through reset and rises on
    // the first clock edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            shifting_r  <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            shifting_r  <= shifting_nxt_s;
        end
    end

    // Capture mux. Bit c-DEPTH of the word appears on sr_so at the start of
    // shift cycle c. Samples taken for c < DEPTH are stale chain contents.
    always_comb begin
        rx_next_s = rx_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt_r == CW'(i + DEPTH)) begin
                rx_next_s[i] = sr_so;
            end else begin
                rx_next_s[i] = rx_r[i];
            end
        end
    end

    // Datapath: transmit shifter, receive word, cycle counter and result.
    // The counter only advances while shifting, so it holds at WIDTH+DEPTH
    // until the next accept clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_r       <= '0;
            rx_r       <= '0;
            bit_cnt_r  <= '0;
            out_data_r <= '0;
        end else if (accept_s) begin
            tx_r      <= bus.in_data;
            rx_r      <= '0;
            bit_cnt_r <= '0;
        end else if ((state_r == SHIFT) || (state_r == FLUSH)) begin
            // Zero fill means tx_r is already empty by the time FLUSH starts.
            tx_r      <= tx_r >> 1;
            rx_r      <= rx_next_s;
            bit_cnt_r <= bit_cnt_r + CW'(1);
            if ((state_r == FLUSH) && (bit_cnt_r == LAST_FLUSH)) begin
                out_data_r <= rx_next_s;
            end else begin
                out_data_r <= out_data_r;
            end
        end else begin
            tx_r       <= tx_r;
            rx_r       <= rx_r;
            bit_cnt_r  <= bit_cnt_r;
            out_data_r <= out_data_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign sr_en         = shifting_r;
    assign busy          = shifting_r;
    // tx_r is zero outside SHIFT, so its LSB is the serial stream.
    assign sr_si         = tx_r[0];
    assign bit_cnt       = bit_cnt_r;
endmodule

// File: tb/tb_siso_shift_ctrl.sv
module tb_siso_shift_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default instance: WIDTH=8, DEPTH=3.
    siso_shift_ctrl_if #(.WIDTH(8)) bus1 ();
    logic       sr_en1, sr_si1, sr_so1, busy1;
    logic [3:0] bit_cnt1;
    logic [2:0] ch1 = 3'b111;

    siso_shift_ctrl #(.WIDTH(8), .DEPTH(3)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .sr_en(sr_en1), .sr_si(sr_si1), .sr_so(sr_so1),
        .busy(busy1), .bit_cnt(bit_cnt1)
    );

    // Model of the 3-stage SISO chain. ch1[0] is the first stage.
    always @(posedge clk) begin
        if (sr_en1) ch1 <= {ch1[1:0], sr_si1};
    end
    assign sr_so1 = ch1[2];

    // Variant instance: WIDTH=4, DEPTH=1.
    siso_shift_ctrl_if #(.WIDTH(4)) bus2 ();
    logic       sr_en2, sr_si2, sr_so2, busy2;
    logic [2:0] bit_cnt2;
    logic       ch2 = 1'b1;

    siso_shift_ctrl #(.WIDTH(4), .DEPTH(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .sr_en(sr_en2), .sr_si(sr_si2), .sr_so(sr_so2),
        .busy(busy2), .bit_cnt(bit_cnt2)
    );

    always @(posedge clk) begin
        if (sr_en2) ch2 <= sr_si2;
    end
    assign sr_so2 = ch2;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready1();
        int k;
        k = 0;
        while (!bus1.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", bus1.in_ready, 1);
    endtask

    // Send one word to dut1 and check the full transfer.
    // If poke > 0, in_valid is pulsed with 0xFF during cycle poke; the
    // controller must ignore it.
    task automatic run_xfer(input logic [7:0] word, input logic [7:0] exp,
                            input logic [10:0] exp_seq, input int poke, input string nm);
        int n;
        int en_cnt;
        logic [10:0] seq;
        bit seen;
        wait_ready1();
        bus1.in_valid = 1'b1;
        bus1.in_data  = word;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        n = 1; en_cnt = 0; seq = '0; seen = 1'b0;
        while (n < 40 && !seen) begin
            if (bus1.out_valid) begin
                seen = 1'b1;
            end else begin
                if (sr_en1) begin
                    if (en_cnt < 11) seq[en_cnt] = sr_si1;
                    en_cnt++;
                end
                if (n == poke) begin
                    chk({nm, "_ready_busy"}, bus1.in_ready, 0);
                    bus1.in_valid = 1'b1;
                    bus1.in_data  = 8'hFF;
                end else begin
                    bus1.in_valid = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        bus1.in_valid = 1'b0;
        chk({nm, "_valid_seen"}, seen, 1);
        chk({nm, "_latency"}, n, 12);
        chk({nm, "_sr_en_cycles"}, en_cnt, 11);
        chk({nm, "_sr_si_seq"}, seq, exp_seq);
        chk({nm, "_out_data"}, bus1.out_data, exp);
        chk({nm, "_ready_in_done"}, bus1.in_ready, 0);
        chk({nm, "_busy_in_done"}, busy1, 0);
        if (bus1.out_ready) begin
            @(negedge clk);
            chk({nm, "_valid_drop"}, bus1.out_valid, 0);
            chk({nm, "_ready_back"}, bus1.in_ready, 1);
            chk({nm, "_data_held"}, bus1.out_data, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  word;
        logic [7:0]  exp_out;
        logic [10:0] exp_seq;
        string       nm;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, en_cnt, t, idx, nr, extra;
        bit acc;
        logic [7:0] words[3];
        logic [7:0] got[3];
        int rise[3];

        vecs[0] = '{8'hA5, 8'hA5, 11'h0A5, "loop_a5"};
        vecs[1] = '{8'hC3, 8'hC3, 11'h0C3, "loop_c3"};
        vecs[2] = '{8'h7E, 8'h7E, 11'h07E, "loop_7e"};
        vecs[3] = '{8'h01, 8'h01, 11'h001, "loop_01"};
        vecs[4] = '{8'h80, 8'h80, 11'h080, "loop_80"};

        rst = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Outputs while reset is held.
        chk("rst_in_ready", bus1.in_ready, 0);
        chk("rst_sr_en", sr_en1, 0);
        chk("rst_sr_si", sr_si1, 0);
        chk("rst_out_valid", bus1.out_valid, 0);
        chk("rst_out_data", bus1.out_data, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_bit_cnt", bit_cnt1, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", bus1.in_ready, 1);

        // Table of basic loopback transfers.
        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i].word, vecs[i].exp_out, vecs[i].exp_seq, 0, vecs[i].nm);
        end

        // Backpressure: out_ready is held low for 5 cycles after out_valid.
        bus1.out_ready = 1'b0;
        run_xfer(8'h3C, 8'h3C, 11'h03C, 0, "bp_3c");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", bus1.out_valid, 1);
            chk("bp_data_hold", bus1.out_data, 8'h3C);
            chk("bp_ready_low", bus1.in_ready, 0);
        end
        bus1.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", bus1.out_valid, 0);
        chk("bp_release_ready", bus1.in_ready, 1);

        // Busy rejection: 0xFF is offered in cycle 3 of the 0x01 transfer.
        run_xfer(8'h01, 8'h01, 11'h001, 3, "busy_rej");
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus1.out_valid) extra++;
            @(negedge clk);
        end
        chk("busy_rej_extra_pulses", extra, 0);
        chk("busy_rej_idle_ready", bus1.in_ready, 1);

        // Reset while SHIFT of 0x96 is at bit_cnt=4.
        wait_ready1();
        bus1.in_valid = 1'b1; bus1.in_data = 8'h96;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        n = 0;
        while (bit_cnt1 != 4'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_cnt4", bit_cnt1, 4);
        chk("abort_busy_before", busy1, 1);
        rst = 1'b1;
        #1;
        chk("abort_sr_en", sr_en1, 0);
        chk("abort_busy", busy1, 0);
        chk("abort_out_valid", bus1.out_valid, 0);
        chk("abort_bit_cnt", bit_cnt1, 0);
        chk("abort_in_ready", bus1.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", bus1.in_ready, 1);
        run_xfer(8'h5A, 8'h5A, 11'h05A, 0, "after_abort_5a");

        // Back-to-back words with in_valid held high.
        words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'h80;
        got[0] = '0; got[1] = '0; got[2] = '0;
        rise[0] = 0; rise[1] = 0; rise[2] = 0;
        wait_ready1();
        idx = 0; t = 0; nr = 0;
        bus1.in_data = words[0];
        bus1.in_valid = 1'b1;
        while (t < 80 && nr < 3) begin
            acc = bus1.in_valid && bus1.in_ready;
            @(negedge clk);
            t++;
            if (acc) begin
                idx++;
                if (idx < 3) bus1.in_data = words[idx];
                else bus1.in_valid = 1'b0;
            end
            if (bus1.out_valid) begin
                got[nr] = bus1.out_data;
                rise[nr] = t;
                nr++;
            end
        end
        bus1.in_valid = 1'b0;
        chk("b2b_count", nr, 3);
        for (int i = 0; i < nr; i++) begin
            chk($sformatf("b2b_data%0d", i), got[i], words[i]);
        end
        if (nr == 3) begin
            chk("b2b_interval01", rise[1] - rise[0], 13);
            chk("b2b_interval12", rise[2] - rise[1], 13);
        end

        // Parameter variant: WIDTH=4, DEPTH=1.
        n = 0;
        while (!bus2.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("var_ready", bus2.in_ready, 1);
        bus2.in_valid = 1'b1; bus2.in_data = 4'h9;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        n = 1; en_cnt = 0;
        while (n < 30 && !bus2.out_valid) begin
            if (sr_en2) en_cnt++;
            @(negedge clk);
            n++;
        end
        chk("var_latency", n, 6);
        chk("var_sr_en_cycles", en_cnt, 5);
        chk("var_out_data", bus2.out_data, 4'h9);
        chk("var_out_valid", bus2.out_valid, 1);
        @(negedge clk);
        chk("var_valid_drop", bus2.out_valid, 0);
        chk("var_ready_back", bus2.in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/siso_shift_ctrl.md
# siso_shift_ctrl

Sequencing controller for the serial-in/serial-out right-shift register datapath. Accepts a parallel word through a valid/ready handshake and drives it LSB-first into an external SISO chain of DEPTH stages. It then flushes the chain with zeros while capturing the bits that emerge at the far end, and presents the reassembled word through a second valid/ready handshake. It is the loopback/serializer sequencer that sits between a parallel producer/consumer and the SISO register.

## Interface
- WIDTH, 8, word length in bits (≥1)
- DEPTH, 3, number of stages in the attached SISO register (≥1); must match the instantiated chain
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a word on in_data
- in_data  input  WIDTH  word to serialize
- in_ready  output  1  controller can accept a word (high only in IDLE)
- sr_en  output  1  shift enable to SISO register; chain shifts on rising clk when high
- sr_si  output  1  serial bit into SISO register
- sr_so  input  1  serial bit out of SISO register (registered last stage)
- out_valid  output  1  out_data holds a complete received word
- out_data  output  WIDTH  reassembled word
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high in SHIFT or FLUSH
- bit_cnt  output  clog2(WIDTH+DEPTH+1)  shift cycles completed in current transfer

## Operation
- States: IDLE, SHIFT, FLUSH, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, load tx_reg←in_data, clear rx_reg and bit_cnt, go SHIFT.
- SHIFT: sr_en=1, sr_si=tx_reg[0]; each cycle tx_reg shifts right (zero fill) and bit_cnt increments. After WIDTH SHIFT cycles, go FLUSH.
- FLUSH: sr_en=1, sr_si=0; bit_cnt increments. After DEPTH FLUSH cycles (bit_cnt reaches WIDTH+DEPTH), go DONE.
- Capture: shift cycle c runs over 0..WIDTH+DEPTH-1 (c = bit_cnt at cycle start). When c≥DEPTH, rx_reg[c-DEPTH]←sr_so on that edge. Samples for c<DEPTH are stale chain contents and are discarded.
- DONE: out_valid=1, out_data=rx_reg, held stable. On out_valid&&out_ready, go IDLE. out_data keeps its last value in IDLE.
- in_valid outside IDLE is ignored. in_ready is never high while busy or out_valid.
- Reset outputs: in_ready=0 while rst asserted, then 1 in IDLE. sr_en=0, sr_si=0, out_valid=0, out_data=0, busy=0, bit_cnt=0.
- Reset mid-transfer aborts immediately: tx_reg/rx_reg cleared and sr_en drops asynchronously. The SISO chain contents are not cleared by this block.
- Counter never wraps. It saturates logically at WIDTH+DEPTH and is cleared on the next accept.

## Timing
- Accept edge E0 → SHIFT in cycle 1. sr_en is high for exactly WIDTH+DEPTH consecutive cycles (cycles 1..WIDTH+DEPTH).
- out_valid rises in cycle WIDTH+DEPTH+1 after the accept edge (12 for defaults).
- With out_ready held high, out_valid lasts exactly 1 cycle and in_ready returns the next cycle.
- Minimum accept-to-accept interval: WIDTH+DEPTH+2 cycles.
- All outputs are registered or decoded from state only. sr_so is sampled only on clock edges.

## Test plan
- Bench model: DEPTH-stage SISO right-shift register driven by sr_en/sr_si, so=last stage. Defaults WIDTH=8, DEPTH=3.
- Basic loopback: send 0xA5 with out_ready=1 → sr_si over the 11 sr_en cycles = 1,0,1,0,0,1,0,1,0,0,0; out_valid high 12 cycles after accept; out_data=0xA5.
- Backpressure: send 0x3C, hold out_ready=0 for 5 cycles after out_valid → out_valid and out_data=0x3C stable, in_ready=0 throughout; release → IDLE next cycle.
- Busy rejection: pulse in_valid with 0xFF during SHIFT of 0x01 → 0xFF ignored; out_data=0x01; only one out_valid pulse.
- Reset mid-SHIFT: assert rst at bit_cnt=4 while sending 0x96 → sr_en, busy, out_valid, bit_cnt all 0 immediately. After release: in_ready=1; a new 0x5A transfer returns 0x5A (stale chain bits discarded).
- Back-to-back and corners: 0xFF then 0x00 then 0x80 with in_valid held high → three results 0xFF, 0x00, 0x80 with interval exactly 13 cycles.
- Parameter variant: rerun with WIDTH=4, DEPTH=1, word 0x9 → out_data 0x9 after 6 cycles.
